uart_decoder: RTL and testbench

- Receive-side counterpart of the UART transmit encoder. It pops bytes from the UART RX FIFO and tracks the tagged 6-byte player frames.
- It rebuilds the remote player's id, X/Y position and collision flag, and publishes them atomically with a one-cycle valid strobe.
- Position: between the UART receiver FIFO (r_data/rx_empty/rd_uart) and the game logic on the receiving board.

---
 rtl/uart_decoder.sv | 187 ++++++++++++++++++
 tb/tb_uart_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_decoder.sv
// rtl/uart_decoder.sv - pops tagged UART bytes and commits 6-byte remote player frames
// Fetch FSM (idle/pop/decode) feeds a frame tracker with an inter-byte timeout.
module uart_decoder #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_empty,
  input  logic [7:0]       r_data,
  output logic             rd_uart,
  output logic [1:0]       remote_player,
  output logic [7:0]       remote_x,
  output logic [7:0]       remote_y,
  output logic             remote_collision,
  output logic             frame_valid,
  output logic             frame_error,
  output logic [ERR_W-1:0] err_count
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             rd_uart_q, rd_uart_d;
  logic [2:0]       expected_q, expected_d;
  logic [1:0]       sh_player_q, sh_player_d;
  logic [7:0]       sh_x_q, sh_x_d;
  logic [7:0]       sh_y_q, sh_y_d;
  logic [1:0]       remote_player_q, remote_player_d;
  logic [7:0]       remote_x_q, remote_x_d;
  logic [7:0]       remote_y_q, remote_y_d;
  logic             remote_collision_q, remote_collision_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_error_q, frame_error_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [2:0] tag;
  logic [3:0] nib;
  logic       illegal;

  assign tag     = byte_q[2:0];
  assign nib     = byte_q[6:3];
  assign illegal = byte_q[7] | (tag > 3'd5);

  always_comb begin
    state_d            = state_q;
    byte_d             = byte_q;
    rd_uart_d          = 1'b0;
    expected_d         = expected_q;
    sh_player_d        = sh_player_q;
    sh_x_d             = sh_x_q;
    sh_y_d             = sh_y_q;
    remote_player_d    = remote_player_q;
    remote_x_d         = remote_x_q;
    remote_y_d         = remote_y_q;
    remote_collision_d = remote_collision_q;
    frame_valid_d      = 1'b0;
    frame_error_d      = 1'b0;
    err_count_d        = err_count_q;
    timer_d            = '0;

    // Timer only ages a partially received frame; a decode always restarts it.
    if (state_q != S_DECODE && expected_q != 3'd0) begin
      if (timer_q == TMR_LAST) begin
        frame_error_d = 1'b1;
        expected_d    = 3'd0;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_empty) begin
          byte_d    = r_data;
          rd_uart_d = 1'b1;
          state_d   = S_POP;
        end
      end
      S_POP: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (illegal) begin
          frame_error_d = (expected_q != 3'd0);
          expected_d    = 3'd0;
          sh_player_d   = 2'b00;
          sh_x_d        = 8'h00;
          sh_y_d        = 8'h00;
        end else if (tag == 3'd0) begin
          // Restart from tag 0 is only an abort once real payload was taken.
          frame_error_d = (expected_q >= 3'd2);
          sh_player_d   = byte_q[4:3];
          expected_d    = 3'd1;
        end else if (expected_q == 3'd0) begin
          expected_d = 3'd0;
        end else if (tag == expected_q && tag <= 3'd4) begin
          case (tag)
            3'd1:    sh_x_d[3:0] = nib;
            3'd2:    sh_x_d[7:4] = nib;
            3'd3:    sh_y_d[7:4] = nib;
            default: sh_y_d[3:0] = nib;
          endcase
          expected_d = expected_q + 3'd1;
        end else if (tag == 3'd5 && expected_q == 3'd5) begin
          if (sh_player_q[0]) begin
            remote_player_d    = sh_player_q;
            remote_x_d         = sh_x_q;
            remote_y_d         = sh_y_q;
            remote_collision_d = byte_q[3];
            frame_valid_d      = 1'b1;
          end
          expected_d = 3'd0;
        end else begin
          frame_error_d = 1'b1;
          expected_d    = 3'd0;
          sh_player_d   = 2'b00;
          sh_x_d        = 8'h00;
          sh_y_d        = 8'h00;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (frame_error_d && err_count_q != {ERR_W{1'b1}}) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      byte_q             <= 8'h00;
      rd_uart_q          <= 1'b0;
      expected_q         <= 3'd0;
      sh_player_q        <= 2'b00;
      sh_x_q             <= 8'h00;
      sh_y_q             <= 8'h00;
      remote_player_q    <= 2'b00;
      remote_x_q         <= 8'h00;
      remote_y_q         <= 8'h00;
      remote_collision_q <= 1'b0;
      frame_valid_q      <= 1'b0;
      frame_error_q      <= 1'b0;
      err_count_q        <= '0;
      timer_q            <= '0;
    end else begin
      state_q            <= state_d;
      byte_q             <= byte_d;
      rd_uart_q          <= rd_uart_d;
      expected_q         <= expected_d;
      sh_player_q        <= sh_player_d;
      sh_x_q             <= sh_x_d;
      sh_y_q             <= sh_y_d;
      remote_player_q    <= remote_player_d;
      remote_x_q         <= remote_x_d;
      remote_y_q         <= remote_y_d;
      remote_collision_q <= remote_collision_d;
      frame_valid_q      <= frame_valid_d;
      frame_error_q      <= frame_error_d;
      err_count_q        <= err_count_d;
      timer_q            <= timer_d;
    end
  end

  assign rd_uart          = rd_uart_q;
  assign remote_player    = remote_player_q;
  assign remote_x         = remote_x_q;
  assign remote_y         = remote_y_q;
  assign remote_collision = remote_collision_q;
  assign frame_valid      = frame_valid_q;
  assign frame_error      = frame_error_q;
  assign err_count        = err_count_q;

endmodule

// File: tb/tb_uart_decoder.sv
// tb/tb_uart_decoder.sv - randomized bench for uart_decoder against a frame-level reference model
// A behavioural RX FIFO feeds the DUT; a tag-level model predicts every output cycle by cycle.
module tb_uart_decoder;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic [1:0] remote_player;
  logic [7:0] remote_x, remote_y;
  logic       remote_collision, frame_valid, frame_error;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  uart_decoder #(.TIMEOUT_CYCLES(TMO), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .remote_player(remote_player), .remote_x(remote_x), .remote_y(remote_y),
    .remote_collision(remote_collision), .frame_valid(frame_valid),
    .frame_error(frame_error), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO contents: the main process only appends, the monitor only advances head_idx.
  logic [7:0] stream[$];
  int head_idx = 0;

  // Reference model state
  int m_exp = 0, sh_p = 0, sh_x = 0, sh_y = 0;
  int r_p = 0, r_x = 0, r_y = 0, r_c = 0, m_err = 0;
  int cyc = 0, last_dec = 0;
  bit pop1_v = 0, pop2_v = 0, rd_prev = 0;
  logic [7:0] pop1_b = 8'h00, pop2_b = 8'h00;
  int rd_pulses = 0, n_valid = 0, n_error = 0;

  task automatic model_reset();
    m_exp = 0; sh_p = 0; sh_x = 0; sh_y = 0;
    r_p = 0; r_x = 0; r_y = 0; r_c = 0; m_err = 0;
  endtask

  task automatic model_decode(input logic [7:0] b, output bit v, output bit e);
    int t;
    int n;
    t = int'(b) % 8;
    n = (int'(b) / 8) % 16;
    v = 0;
    e = 0;
    if (int'(b) >= 128 || t > 5) begin
      e = (m_exp != 0);
      m_exp = 0;
    end else if (t == 0) begin
      e = (m_exp >= 2);
      m_exp = 1;
      sh_p = n % 4;
    end else if (m_exp == 0) begin
      m_exp = 0;
    end else if (t == m_exp && t <= 4) begin
      case (t)
        1: sh_x = (sh_x / 16) * 16 + n;
        2: sh_x = n * 16 + sh_x % 16;
        3: sh_y = n * 16 + sh_y % 16;
        default: sh_y = (sh_y / 16) * 16 + n;
      endcase
      m_exp++;
    end else if (t == 5 && m_exp == 5) begin
      if (sh_p % 2 == 1) begin
        r_p = sh_p; r_x = sh_x; r_y = sh_y; r_c = n % 2;
        v = 1;
      end
      m_exp = 0;
    end else begin
      e = 1;
      m_exp = 0;
    end
  endtask

  // A byte popped in cycle c is decoded in c+1, its effect visible in c+2.
  always @(negedge clk) begin
    bit exp_v;
    bit exp_e;
    cyc++;
    exp_v = 0;
    exp_e = 0;
    if (rst) begin
      model_reset();
      pop1_v = 0;
      pop2_v = 0;
    end else begin
      if (pop2_v) begin
        model_decode(pop2_b, exp_v, exp_e);
        last_dec = cyc - 1;
      end else if (m_exp != 0 && (cyc - 1) - last_dec == TMO) begin
        exp_e = 1;
        m_exp = 0;
      end
      if (exp_e && m_err < 255) m_err++;
    end
    check("frame_valid", frame_valid, exp_v);
    check("frame_error", frame_error, exp_e);
    check("remote_player", remote_player, r_p);
    check("remote_x", remote_x, r_x);
    check("remote_y", remote_y, r_y);
    check("remote_collision", remote_collision, r_c);
    check("err_count", err_count, m_err);
    n_valid += int'(frame_valid);
    n_error += int'(frame_error);
    pop2_v = pop1_v;
    pop2_b = pop1_b;
    pop1_v = 0;
    if (rd_uart) begin
      rd_pulses++;
      check("rd_back_to_back", rd_prev, 0);
      check("rd_on_empty", stream.size() > head_idx, 1);
      if (stream.size() > head_idx) begin
        pop1_b = stream[head_idx];
        head_idx++;
        pop1_v = 1;
      end
    end
    rd_prev = rd_uart;
    rx_empty = !(stream.size() > head_idx);
    r_data = rx_empty ? 8'h00 : stream[head_idx];
  end

  function automatic logic [7:0] enc(input int t, input int n);
    return 8'((n % 16) * 8 + t);
  endfunction

  task automatic push(input logic [7:0] b);
    stream.push_back(b);
  endtask

  task automatic push_frame(input int p, input int x, input int y, input int c);
    push(enc(0, p)); push(enc(1, x % 16)); push(enc(2, x / 16));
    push(enc(3, y / 16)); push(enc(4, y % 16)); push(enc(5, c));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (stream.size() > head_idx && n < bound) begin
      wait_cycles(1);
      n++;
    end
    check("drain", stream.size() - head_idx, 0);
    wait_cycles(6);
  endtask

  initial begin
    int rd0, v0, e0;
    wait_cycles(3);
    rst = 1'b0;
    check("reset_player", remote_player, 0);
    check("reset_x", remote_x, 0);
    check("reset_rd", rd_uart, 0);
    check("reset_err", err_count, 0);

    // Basic frame
    rd0 = rd_pulses; v0 = n_valid; e0 = n_error;
    push(8'h08); push(8'h29); push(8'h52); push(8'h1B); push(8'h64); push(8'h0D);
    drain(200);
    check("s1_player", remote_player, 2'b01);
    check("s1_x", remote_x, 8'hA5);
    check("s1_y", remote_y, 8'h3C);
    check("s1_coll", remote_collision, 1);
    check("s1_rd_count", rd_pulses - rd0, 6);
    check("s1_valid_count", n_valid - v0, 1);

    // Filler bytes ahead of a frame restart silently
    v0 = n_valid; e0 = n_error;
    push(8'h00); push(8'h00);
    push(8'h08); push(8'h29); push(8'h52); push(8'h1B); push(8'h64); push(8'h0D);
    drain(200);
    check("s2_errors", n_error - e0, 0);
    check("s2_valid_count", n_valid - v0, 1);
    check("s2_x", remote_x, 8'hA5);

    // Idle frame
    v0 = n_valid; e0 = n_error;
    push(8'h00); push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
    drain(200);
    check("s3_valid_count", n_valid - v0, 0);
    check("s3_errors", n_error - e0, 0);
    check("s3_y", remote_y, 8'h3C);

    // Skipped tag, then a good frame for player 11
    v0 = n_valid; e0 = n_error;
    push(8'h08); push(8'h29); push(8'h1B);
    drain(200);
    check("s4_errors", n_error - e0, 1);
    check("s4_err_count", err_count, 1);
    check("s4_x_held", remote_x, 8'hA5);
    push_frame(3, 8'h5E, 8'h81, 0);
    drain(200);
    check("s4_player", remote_player, 2'b11);
    check("s4_x", remote_x, 8'h5E);
    check("s4_y", remote_y, 8'h81);
    check("s4_coll", remote_collision, 0);

    // Timeout on a starved frame; late bytes are discarded
    v0 = n_valid; e0 = n_error;
    push(8'h08); push(8'h29);
    drain(200);
    wait_cycles(TMO + 8);
    check("s5_timeout", n_error - e0, 1);
    push(8'h52); push(8'h1B); push(8'h64); push(8'h0D);
    drain(200);
    check("s5_no_commit", n_valid - v0, 0);
    check("s5_no_more_err", n_error - e0, 1);

    // Randomized frames: clean, corrupted, dropped byte, or stalled mid-frame
    for (int it = 0; it < 40; it++) begin
      logic [7:0] fb[6];
      int mode, k, p, x, y, c;
      p = $urandom_range(0, 3);
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      c = $urandom_range(0, 1);
      fb[0] = enc(0, p); fb[1] = enc(1, x % 16); fb[2] = enc(2, x / 16);
      fb[3] = enc(3, y / 16); fb[4] = enc(4, y % 16); fb[5] = enc(5, c);
      mode = $urandom_range(0, 3);
      k = $urandom_range(0, 5);
      if (mode == 1) fb[k] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
        if (mode == 2 && i == k) continue;
        if (mode == 3 && i == k) begin
          drain(200);
          wait_cycles(TMO + 4);
        end
        push(fb[i]);
        if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 5));
      end
      drain(200);
    end

    // Reset mid-frame
    push_frame(1, 8'hC3, 8'h7E, 1);
    drain(200);
    push(8'h08); push(8'h29); push(8'h52);
    drain(200);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check("rst_player", remote_player, 0);
    check("rst_x", remote_x, 0);
    check("rst_y", remote_y, 0);
    check("rst_coll", remote_collision, 0);
    check("rst_err_count", err_count, 0);
    v0 = n_valid; e0 = n_error;
    push(8'h1B); push(8'h64); push(8'h0D);
    drain(200);
    check("rst_leftover_valid", n_valid - v0, 0);
    check("rst_leftover_err", n_error - e0, 0);

    // Saturation of the error counter
    e0 = n_error;
    for (int i = 0; i < 300; i++) begin
      push(8'h08);
      push(8'hFF);
    end
    drain(3000);
    check("sat_pulses", n_error - e0, 300);
    check("sat_err_count", err_count, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
